// File: rtl/dino_pkg.sv
// Shared constants and FSM state type for the dino-game collision path.
package dino_pkg;
  localparam int X_W = 12;
  localparam int Y_W = 10;

  localparam int DINO_X_DEF   = 100;
  localparam int DINO_W_DEF   = 40;
  localparam int DINO_H_DEF   = 43;
  localparam int CACTUS_W_DEF = 25;
  localparam int CACTUS_H_DEF = 50;
  localparam int GROUND_Y_DEF = 400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2
  } state_t;
endpackage

// File: rtl/hitbox_compare.sv
// Combinational test of one cactus against the dino hitbox: overlap and exact-clear detection.
module hitbox_compare
  import dino_pkg::*;
#(
  parameter int DINO_X   = DINO_X_DEF,
  parameter int DINO_W   = DINO_W_DEF,
  parameter int DINO_H   = DINO_H_DEF,
  parameter int CACTUS_W = CACTUS_W_DEF,
  parameter int CACTUS_H = CACTUS_H_DEF,
  parameter int GROUND_Y = GROUND_Y_DEF
) (
  input  logic signed [X_W-1:0] cx,
  input  logic        [Y_W-1:0] dino_y,
  output logic                  overlap,
  output logic                  cleared
);
  localparam int XE_W = X_W + 2;
  localparam int YE_W = Y_W + 1;

  localparam logic signed [XE_W-1:0] C_RIGHT = XE_W'(DINO_X + DINO_W);
  localparam logic signed [XE_W-1:0] C_LEFT  = XE_W'(DINO_X);
  localparam logic signed [XE_W-1:0] C_CW    = XE_W'(CACTUS_W);
  localparam logic signed [XE_W-1:0] C_CLR   = XE_W'(DINO_X - CACTUS_W);
  localparam logic        [YE_W-1:0] C_TOP   = YE_W'(GROUND_Y - CACTUS_H);
  localparam logic        [YE_W-1:0] C_DH    = YE_W'(DINO_H);

  logic signed [XE_W-1:0] w_cx;
  logic signed [XE_W-1:0] w_cx_right;
  logic        [YE_W-1:0] w_dino_bot;
  logic                   w_x_ovl;
  logic                   w_y_ovl;

  // Two guard bits keep off-screen (negative) cactuses from wrapping into the window.
  assign w_cx       = {{2{cx[X_W-1]}}, cx};
  assign w_cx_right = w_cx + C_CW;
  assign w_dino_bot = {1'b0, dino_y} + C_DH;

  assign w_x_ovl = (w_cx < C_RIGHT) && (w_cx_right > C_LEFT);
  assign w_y_ovl = (w_dino_bot > C_TOP);

  assign overlap = w_x_ovl && w_y_ovl;
  assign cleared = (w_cx == C_CLR);
endmodule

// File: rtl/collision_detector.sv
// Snapshots cactus positions on each sync edge, scans one slot per cycle, latches game_over and keeps score.
module collision_detector
  import dino_pkg::*;
#(
  parameter int DINO_X   = DINO_X_DEF,
  parameter int DINO_W   = DINO_W_DEF,
  parameter int DINO_H   = DINO_H_DEF,
  parameter int CACTUS_W = CACTUS_W_DEF,
  parameter int CACTUS_H = CACTUS_H_DEF,
  parameter int GROUND_Y = GROUND_Y_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cactus_sync,
  input  logic signed [X_W-1:0] cactus0,
  input  logic signed [X_W-1:0] cactus1,
  input  logic signed [X_W-1:0] cactus2,
  input  logic signed [X_W-1:0] cactus3,
  input  logic        [Y_W-1:0] dino_y,
  input  logic                  restart,
  output logic                  game_over,
  output logic        [1:0]     hit_slot,
  output logic        [15:0]    score,
  output logic                  check_done
);
  state_t                r_state;
  logic                  r_sync_d;
  logic signed [X_W-1:0] r_snap [4];
  logic        [Y_W-1:0] r_snap_y;
  logic        [1:0]     r_slot;
  logic                  r_pend;
  logic                  r_game_over;
  logic        [1:0]     r_hit_slot;
  logic        [15:0]    r_score;
  logic                  r_check_done;

  logic signed [X_W-1:0] w_cx;
  logic                  w_overlap;
  logic                  w_cleared;
  logic                  w_sync_rise;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_sync_rise = cactus_sync && !r_sync_d;
  assign w_cx        = r_snap[r_slot];

  hitbox_compare #(
    .DINO_X  (DINO_X),
    .DINO_W  (DINO_W),
    .DINO_H  (DINO_H),
    .CACTUS_W(CACTUS_W),
    .CACTUS_H(CACTUS_H),
    .GROUND_Y(GROUND_Y)
  ) u_cmp (
    .cx     (w_cx),
    .dino_y (r_snap_y),
    .overlap(w_overlap),
    .cleared(w_cleared)
  );

  // r_pend marks the extra cycle that emits check_done after a scan ends or a hit is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sync_d     <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
      r_snap_y     <= '0;
      r_slot       <= '0;
      r_pend       <= 1'b0;
      r_game_over  <= 1'b0;
      r_hit_slot   <= '0;
      r_score      <= '0;
      r_check_done <= 1'b0;
    end else begin
      r_sync_d     <= cactus_sync;
      r_check_done <= 1'b0;
      if (restart) begin
        r_state     <= IDLE;
        for (int i = 0; i < 4; i++) r_snap[i] <= '0;
        r_snap_y    <= '0;
        r_slot      <= '0;
        r_pend      <= 1'b0;
        r_game_over <= 1'b0;
        r_hit_slot  <= '0;
        r_score     <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_sync_rise) begin
              r_snap[0] <= cactus0;
              r_snap[1] <= cactus1;
              r_snap[2] <= cactus2;
              r_snap[3] <= cactus3;
              r_snap_y  <= dino_y;
              r_slot    <= '0;
              r_pend    <= 1'b0;
              r_state   <= SCAN;
            end
          end
          SCAN: begin
            if (r_pend) begin
              r_check_done <= 1'b1;
              r_pend       <= 1'b0;
              r_state      <= IDLE;
            end else if (w_overlap) begin
              r_game_over <= 1'b1;
              r_hit_slot  <= r_slot;
              r_pend      <= 1'b1;
              r_state     <= HIT;
            end else begin
              if (w_cleared) r_score <= sat_inc(r_score);
              if (r_slot == 2'd3) r_pend <= 1'b1;
              else                r_slot <= r_slot + 2'd1;
            end
          end
          HIT: begin
            if (r_pend) begin
              r_check_done <= 1'b1;
              r_pend       <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign game_over  = r_game_over;
  assign hit_slot   = r_hit_slot;
  assign score      = r_score;
  assign check_done = r_check_done;
endmodule

// File: tb/tb_collision_detector.sv
// Directed bench for collision_detector: scan timing, hits, clears, freeze, restart and saturation.
module tb_collision_detector;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cactus_sync;
  logic [11:0] cactus0, cactus1, cactus2, cactus3;
  logic [9:0]  dino_y;
  logic        restart;
  logic        game_over;
  logic [1:0]  hit_slot;
  logic [15:0] score;
  logic        check_done;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses;

  collision_detector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cactus_sync(cactus_sync),
    .cactus0    (cactus0),
    .cactus1    (cactus1),
    .cactus2    (cactus2),
    .cactus3    (cactus3),
    .dino_y     (dino_y),
    .restart    (restart),
    .game_over  (game_over),
    .hit_slot   (hit_slot),
    .score      (score),
    .check_done (check_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cactus(input logic [11:0] a, input logic [11:0] b,
                            input logic [11:0] c, input logic [11:0] d, input logic [9:0] y);
    cactus0 = a; cactus1 = b; cactus2 = c; cactus3 = d; dino_y = y;
  endtask

  // Returns at the negedge right after the snapshot edge (offset 0).
  task automatic sync_pulse();
    cactus_sync = 1'b1;
    @(negedge clk);
    cactus_sync = 1'b0;
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (check_done) cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; cactus_sync = 1'b0; restart = 1'b0;
    set_cactus(12'd0, 12'd0, 12'd0, 12'd0, 10'd0);
    tick(2);
    check("rst_game_over", game_over, 0);
    check("rst_hit_slot", hit_slot, 0);
    check("rst_score", score, 0);
    check("rst_check_done", check_done, 0);
    rst_n = 1'b1;
    tick(1);

    // Asynchronous reset in the middle of a scan.
    set_cactus(12'd75, 12'hB38, 12'hB06, 12'h8AD, 10'd357);
    sync_pulse();
    tick(1);
    check("midscan_score_before", score, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_score", score, 0);
    check("async_rst_game_over", game_over, 0);
    check("async_rst_check_done", check_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(8, pulses);
    check("async_rst_scan_discarded", pulses, 0);
    check("async_rst_score_held", score, 0);

    // No hit, strobe held for many cycles.
    set_cactus(12'd300, 12'hB38, 12'hB06, 12'h8AD, 10'd357);
    cactus_sync = 1'b1;
    @(negedge clk);
    tick(4);
    check("nohit_done_n4", check_done, 0);
    tick(1);
    check("nohit_done_n5", check_done, 1);
    check("nohit_game_over", game_over, 0);
    check("nohit_score", score, 0);
    count_done(10, pulses);
    check("held_sync_single_scan", pulses, 0);
    cactus_sync = 1'b0;
    tick(1);

    // Jump over a cactus in the window.
    set_cactus(12'd110, 12'hB38, 12'hB06, 12'h8AD, 10'd300);
    sync_pulse();
    tick(5);
    check("jump_done", check_done, 1);
    check("jump_game_over", game_over, 0);
    check("jump_score", score, 0);

    // Cactus exactly cleared scores once.
    set_cactus(12'd75, 12'hB38, 12'hB06, 12'h8AD, 10'd300);
    sync_pulse();
    tick(1);
    check("clear_score_n1", score, 1);
    tick(4);
    check("clear_done", check_done, 1);
    check("clear_score_n5", score, 1);
    check("clear_game_over", game_over, 0);

    // Ground collision on slot 2, slot 0 cleared first.
    set_cactus(12'd75, 12'hB38, 12'd110, 12'h8AD, 10'd357);
    sync_pulse();
    tick(2);
    check("coll_go_n2", game_over, 0);
    tick(1);
    check("coll_go_n3", game_over, 1);
    check("coll_slot_n3", hit_slot, 2);
    check("coll_done_n3", check_done, 0);
    tick(1);
    check("coll_done_n4", check_done, 1);
    tick(1);
    check("coll_done_n5", check_done, 0);
    check("coll_score", score, 2);

    // Frozen: further syncs change nothing.
    set_cactus(12'd75, 12'd75, 12'd75, 12'd75, 10'd357);
    sync_pulse();
    count_done(7, pulses);
    check("frozen_no_done", pulses, 0);
    check("frozen_go", game_over, 1);
    check("frozen_slot", hit_slot, 2);
    check("frozen_score", score, 2);

    // Restart together with sync: restart wins, no scan started.
    set_cactus(12'd75, 12'hB38, 12'hB06, 12'h8AD, 10'd357);
    restart = 1'b1; cactus_sync = 1'b1;
    @(negedge clk);
    restart = 1'b0; cactus_sync = 1'b0;
    check("restart_go", game_over, 0);
    check("restart_score", score, 0);
    check("restart_slot", hit_slot, 0);
    check("restart_done", check_done, 0);
    count_done(7, pulses);
    check("restart_sync_dropped", pulses, 0);
    sync_pulse();
    tick(5);
    check("fresh_done", check_done, 1);
    check("fresh_score", score, 1);
    check("fresh_go", game_over, 0);

    // Restart beats a hit on the same edge.
    set_cactus(12'd110, 12'hB38, 12'hB06, 12'h8AD, 10'd357);
    sync_pulse();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_vs_hit_go", game_over, 0);
    check("restart_vs_hit_score", score, 0);
    count_done(6, pulses);
    check("restart_vs_hit_no_done", pulses, 0);

    // Saturation from FFFE with two clears; FFF (-1) on the ground does not overlap.
    set_cactus(12'd75, 12'd75, 12'hB06, 12'hFFF, 10'd357);
    force dut.r_score = 16'hFFFE;
    #1 release dut.r_score;
    @(negedge clk);
    sync_pulse();
    tick(1);
    check("sat_score_n1", score, 16'hFFFF);
    tick(4);
    check("sat_score_n5", score, 16'hFFFF);
    check("sat_done", check_done, 1);
    check("neg_cx_no_overlap", game_over, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
